// File: rtl/dpwm_ctrl_if.sv
// dpwm_ctrl_if: command/status bundle between a supervisor and the dpwm soft-start controller
interface dpwm_ctrl_if;
  logic        i_ts_last;
  logic        i_start;
  logic        i_stop;
  logic        i_fault;
  logic        i_fault_clr;
  logic [11:0] i_ton_target;
  logic        o_enable;
  logic [11:0] o_ton;
  logic [2:0]  o_state;
  logic        o_pgood;
  logic        o_clamp;
  modport master (
    output i_ts_last, i_start, i_stop, i_fault, i_fault_clr, i_ton_target,
    input  o_enable, o_ton, o_state, o_pgood, o_clamp
  );
  modport slave (
    input  i_ts_last, i_start, i_stop, i_fault, i_fault_clr, i_ton_target,
    output o_enable, o_ton, o_state, o_pgood, o_clamp
  );
endinterface

// File: rtl/dpwm_ctrl.sv
// dpwm_ctrl: precharge / soft-start / run / soft-stop / fault sequencer for dpwm; DPWM_CTRL_SLEW_EN slew-limits on-time changes in RUN
module dpwm_ctrl #(
  parameter int TON_MAX     = 116,
  parameter int STEP        = 2,
  parameter int RAMP_DIV    = 4,
  parameter int PRE_PERIODS = 8
) (
  input  logic     i_clk,
  input  logic     reset_n,
  dpwm_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, RAMP = 3'd2, RUN = 3'd3, SHDN = 3'd4, FAULT = 3'd5} state_t;
  localparam logic [12:0] TMAX    = 13'(TON_MAX);
  localparam logic [12:0] STP     = 13'(STEP);
  localparam logic [7:0]  DIV_END = 8'(RAMP_DIV - 1);
  localparam logic [7:0]  PRE_END = 8'(PRE_PERIODS - 1);
  logic [1:0]  sync_q, sync_d;
  logic        rst_int_n;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] ton_q, ton_d;
  logic        en_q, en_d;
  logic [12:0] tgt, ton13, up, dn, ramp_val;
  logic        step;
`ifdef DPWM_CTRL_SLEW_EN
  logic [12:0] slew;
`endif
  // reset synchronizer: assert immediately, release after two clean edges
  always_comb sync_d = {sync_q[0], 1'b1};
  always_ff @(posedge i_clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  assign rst_int_n = sync_q[1];
  assign bus.o_clamp = {1'b0, bus.i_ton_target} > TMAX;
  assign tgt      = bus.o_clamp ? TMAX : {1'b0, bus.i_ton_target};
  assign ton13    = {1'b0, ton_q};
  assign up       = ton13 + STP;
  assign dn       = ton13 > STP ? ton13 - STP : 13'd0;
  assign ramp_val = up > tgt ? tgt : up;
  assign step     = bus.i_ts_last && cnt_q == DIV_END;
`ifdef DPWM_CTRL_SLEW_EN
  assign slew = ton13 < tgt ? ramp_val : (dn < tgt ? tgt : dn);
`endif
  // next state and on-time; fault overrides everything and bypasses the period boundary
  always_comb begin
    state_d = state_q;
    ton_d   = ton_q;
    if (bus.i_fault) begin
      state_d = FAULT;
      ton_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ton_d = '0;
          if (bus.i_start) state_d = PRE;
        end
        PRE:
          if (bus.i_stop) state_d = SHDN;
          else if (bus.i_ts_last && cnt_q == PRE_END) state_d = RAMP;
        RAMP:
          if (bus.i_stop) state_d = SHDN;
          else if (bus.i_ts_last && ton13 == tgt) state_d = RUN;
          else if (step) begin
            ton_d = ramp_val[11:0];
            if (ramp_val == tgt) state_d = RUN;
          end
        RUN:
          if (bus.i_stop) state_d = SHDN;
`ifdef DPWM_CTRL_SLEW_EN
          else if (step) ton_d = slew[11:0];
`else
          else if (bus.i_ts_last) ton_d = tgt[11:0];
`endif
        SHDN:
          if (bus.i_ts_last && ton_q == '0) state_d = IDLE;
          else if (step) ton_d = dn[11:0];
        FAULT: begin
          ton_d = '0;
          if (bus.i_fault_clr) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          ton_d   = '0;
        end
      endcase
    end
    en_d  = state_d inside {PRE, RAMP, RUN, SHDN};
    cnt_d = state_d != state_q ? 8'd0 :
            !bus.i_ts_last ? cnt_q :
            (state_q != PRE && cnt_q == DIV_END) ? 8'd0 : cnt_q + 8'd1;
  end
  // state, period counter and registered outputs
  always_ff @(posedge i_clk or negedge rst_int_n)
    if (!rst_int_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ton_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ton_q   <= ton_d;
      en_q    <= en_d;
    end
  assign bus.o_enable = en_q;
  assign bus.o_ton    = ton_q;
  assign bus.o_state  = state_q;
  assign bus.o_pgood  = state_q == RUN;
endmodule
